// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 controller: one forward and one inverse round datapath,
// stepped once per clock through the 10 rounds of a block. The result is held
// on a valid/ready output port until it is taken.
module aes128_iter_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         in_mode_i,
    input  logic [127:0] in_key_i,
    input  logic [127:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         out_mode_o,
    output logic         busy_o,
    output logic [3:0]   round_idx_o
);
    if (NR != 10) begin : g_bad_nr
        $error("aes128_iter_ctrl supports only NR = 10");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    typedef logic [10:0][127:0] rk_t;

    // GF(2^8) arithmetic, modulus x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0)
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] t, r;
        t = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    // Byte j of a block lives at bits [127-8j -: 8]; byte j is row j%4, column j/4.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[8*i +: 8] = inv ? isbox(s[8*i +: 8]) : sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                src = inv ? r + 4 * ((c - r + 4) % 4) : r + 4 * ((c + r) % 4);
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * src -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [3:0][7:0] a;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127 - 32 * c - 8 * r -: 8];
            for (int r = 0; r < 4; r++)
                o[127 - 32 * c - 8 * r -: 8] = inv ?
                    gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b) ^
                    gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09) :
                    gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03) ^
                    a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

    function automatic rk_t key_exp(input logic [127:0] key);
        logic [43:0][31:0] w;
        logic [31:0] t;
        logic [7:0]  rc;
        rk_t rk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return rk;
    endfunction

    logic [1:0]   fsm_q, fsm_d;
    logic [127:0] key_q, key_d;
    logic [127:0] state_q, state_d;
    logic [127:0] out_data_q, out_data_d;
    logic         mode_q, mode_d;
    logic         out_mode_q, out_mode_d;
    logic [3:0]   rnd_q, rnd_d;

    rk_t          ks_in, ks_q;
    logic [127:0] rk_run, enc_rnd, dec_rnd, enc_last, dec_last;

    // Schedules from the live input key (accept whitening) and the latched key (rounds)
    assign ks_in    = key_exp(in_key_i);
    assign ks_q     = key_exp(key_q);
    assign rk_run   = ks_q[rnd_q];
    assign enc_rnd  = mix_cols(shift_rows(sub_bytes(state_q, 1'b0), 1'b0), 1'b0) ^ rk_run;
    assign dec_rnd  = mix_cols(sub_bytes(shift_rows(state_q, 1'b1), 1'b1) ^ rk_run, 1'b1);
    assign enc_last = shift_rows(sub_bytes(state_q, 1'b0), 1'b0) ^ ks_q[10];
    assign dec_last = sub_bytes(shift_rows(state_q, 1'b1), 1'b1) ^ ks_q[0];

    // Next-state: accept, nine middle rounds, final round, hold result until taken
    always_comb begin
        fsm_d      = fsm_q;
        key_d      = key_q;
        state_d    = state_q;
        out_data_d = out_data_q;
        mode_d     = mode_q;
        out_mode_d = out_mode_q;
        rnd_d      = rnd_q;
        case (fsm_q)
            S_IDLE: if (in_valid_i) begin
                key_d   = in_key_i;
                mode_d  = in_mode_i;
                state_d = in_data_i ^ (in_mode_i ? ks_in[10] : ks_in[0]);
                rnd_d   = in_mode_i ? 4'd9 : 4'd1;
                fsm_d   = S_RUN;
            end
            S_RUN: begin
                state_d = mode_q ? dec_rnd : enc_rnd;
                if (mode_q) begin
                    rnd_d = rnd_q - 4'd1;
                    if (rnd_q == 4'd1) fsm_d = S_FINAL;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                    if (rnd_q == 4'd9) fsm_d = S_FINAL;
                end
            end
            S_FINAL: begin
                out_data_d = mode_q ? dec_last : enc_last;
                out_mode_d = mode_q;
                fsm_d      = S_OUT;
            end
            default: if (out_ready_i) fsm_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any block in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= S_IDLE;
            key_q      <= '0;
            state_q    <= '0;
            out_data_q <= '0;
            mode_q     <= 1'b0;
            out_mode_q <= 1'b0;
            rnd_q      <= 4'd0;
        end else begin
            fsm_q      <= fsm_d;
            key_q      <= key_d;
            state_q    <= state_d;
            out_data_q <= out_data_d;
            mode_q     <= mode_d;
            out_mode_q <= out_mode_d;
            rnd_q      <= rnd_d;
        end
    end

    // Round-key index seen by the datapath this cycle
    always_comb begin
        case (fsm_q)
            S_RUN:   round_idx_o = rnd_q;
            S_FINAL: round_idx_o = mode_q ? 4'd0 : 4'd10;
            default: round_idx_o = 4'd0;
        endcase
    end

    assign in_ready_o  = (fsm_q == S_IDLE);
    assign out_valid_o = (fsm_q == S_OUT);
    assign busy_o      = (fsm_q == S_RUN) || (fsm_q == S_FINAL);
    assign out_data_o  = out_data_q;
    assign out_mode_o  = out_mode_q;
endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Bench for aes128_iter_ctrl: FIPS-197 vectors, random blocks against a
// byte-array AES model, back-pressure, input-stability and mid-block reset.
module tb_aes128_iter_ctrl;
    localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
    logic [127:0] in_key = '0, in_data = '0;
    logic         in_ready, out_valid, out_mode, busy;
    logic [127:0] out_data;
    logic [3:0]   round_idx;

    int total = 0;
    int bad = 0;
    logic [7:0]   sb [256];
    logic [7:0]   isb [256];
    logic [127:0] last_out;

    aes128_iter_ctrl #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_mode_i(in_mode),
        .in_key_i(in_key), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_mode_o(out_mode),
        .busy_o(busy), .round_idx_o(round_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // Textbook AES-128 over byte arrays with table S-boxes
    function automatic logic [127:0] model(input logic dec, input logic [127:0] key, input logic [127:0] din);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] rc, b0;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) w[i] = key[127 - 8 * i -: 8];
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i - 4 + j];
            if (i % 16 == 0) begin
                b0 = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[b0];
                rc = gm(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i + j] = w[i - 16 + j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = din[127 - 8 * i -: 8];
        if (!dec) begin
            for (int i = 0; i < 16; i++) s[i] ^= w[i];
            for (int rd = 1; rd <= 10; rd++) begin
                for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
                for (int rw = 0; rw < 4; rw++)
                    for (int c = 0; c < 4; c++) s[rw + 4 * c] = t[rw + 4 * ((c + rw) % 4)];
                if (rd < 10)
                    for (int c = 0; c < 4; c++) begin
                        for (int j = 0; j < 4; j++) tmp[j] = s[4 * c + j];
                        for (int j = 0; j < 4; j++)
                            s[4 * c + j] = gm(tmp[j], 8'h02) ^ gm(tmp[(j + 1) % 4], 8'h03) ^
                                           tmp[(j + 2) % 4] ^ tmp[(j + 3) % 4];
                    end
                for (int i = 0; i < 16; i++) s[i] ^= w[16 * rd + i];
            end
        end else begin
            for (int i = 0; i < 16; i++) s[i] ^= w[160 + i];
            for (int rd = 9; rd >= 0; rd--) begin
                for (int rw = 0; rw < 4; rw++)
                    for (int c = 0; c < 4; c++) t[rw + 4 * ((c + rw) % 4)] = s[rw + 4 * c];
                for (int i = 0; i < 16; i++) s[i] = isb[t[i]] ^ w[16 * rd + i];
                if (rd > 0)
                    for (int c = 0; c < 4; c++) begin
                        for (int j = 0; j < 4; j++) tmp[j] = s[4 * c + j];
                        for (int j = 0; j < 4; j++)
                            s[4 * c + j] = gm(tmp[j], 8'h0e) ^ gm(tmp[(j + 1) % 4], 8'h0b) ^
                                           gm(tmp[(j + 2) % 4], 8'h0d) ^ gm(tmp[(j + 3) % 4], 8'h09);
                    end
            end
        end
        for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = s[i];
        return r;
    endfunction

    task automatic build_tables();
        logic [7:0] inv, o, xv, cst;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            xv = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(xv, y[7:0]) == 8'h01) inv = y[7:0];
            for (int b = 0; b < 8; b++)
                o[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^
                       inv[(b + 6) % 8] ^ inv[(b + 7) % 8] ^ cst[b];
            sb[x] = o;
            isb[o] = xv;
        end
    endtask

    // One block: accept, track latency and round_idx, optional back-pressure, handshake
    task automatic do_block(input logic m, input logic [127:0] k, input logic [127:0] d,
                            input logic [127:0] exp, input bit scramble, input int hold);
        int n;
        logic [127:0] held;
        logic [3:0] idx [$];
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("ready_before", in_ready, 1);
        in_mode = m; in_key = k; in_data = d; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ready_drop", in_ready, 0);
        n = 0;
        while (!out_valid && n < 40) begin
            idx.push_back(round_idx);
            chk("busy", busy, 1);
            if (scramble) begin
                in_key  = {$urandom, $urandom, $urandom, $urandom};
                in_data = {$urandom, $urandom, $urandom, $urandom};
                in_mode = $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 10);
        for (int j = 0; j < idx.size() && j < 10; j++)
            chk("round_idx", idx[j], m ? ((j < 9) ? 9 - j : 0) : j + 1);
        chk("busy_out", busy, 0);
        chk("idx_out", round_idx, 0);
        chk("out_data", out_data, exp);
        chk("out_mode", out_mode, m);
        held = out_data;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_mode = ~m;
            in_key  = {$urandom, $urandom, $urandom, $urandom};
            in_data = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, held);
            chk("bp_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_valid", out_valid, 0);
        chk("hs_ready", in_ready, 1);
        last_out = held;
    endtask

    initial begin
        logic [127:0] k, d, e;
        logic m;
        build_tables();
        chk("model_c1", model(1'b0, C1K, C1P), C1C);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 0);
        chk("rst_mode", out_mode, 0);
        chk("rst_idx", round_idx, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", in_ready, 1);

        do_block(1'b0, C1K, C1P, C1C, 0, 0);
        do_block(1'b1, C1K, C1C, C1P, 0, 0);
        do_block(1'b0, BK, BP, BC, 0, 3);
        do_block(1'b1, C1K, C1C, C1P, 0, 0);
        do_block(1'b0, C1K, C1P, C1C, 0, 20);
        do_block(1'b0, C1K, C1P, C1C, 1, 0);

        // Reset in the fifth RUN cycle
        in_mode = 1'b0; in_key = C1K; in_data = C1P; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_idx", round_idx, 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_idx", round_idx, 0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_valid", out_valid, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_block(1'b0, C1K, C1P, C1C, 0, 0);

        // Random blocks against the model, plus round trips
        for (int i = 0; i < 6; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            d = {$urandom, $urandom, $urandom, $urandom};
            m = $urandom;
            e = model(m, k, d);
            do_block(m, k, d, e, i[0], $urandom_range(0, 3));
            do_block(~m, k, last_out, d, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
